// File: rtl/sad_lane_engine.sv
// Pipelined N-lane sum-of-absolute-differences engine with running-minimum tracking.
// S1 = per-lane |frame-window|, S2 = adder tree, S3 = saturating block accumulator + best match.
module sad_lane_engine #(
  parameter int LANES = 4,
  parameter int PIX_W = 8,
  parameter int ACC_W = 32,
  parameter int TAG_W = 32
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     in_valid,
  input  logic                     in_last,
  input  logic [LANES*PIX_W-1:0]   frame_pix,
  input  logic [LANES*PIX_W-1:0]   window_pix,
  input  logic [TAG_W-1:0]         in_tag,
  input  logic                     min_clear,
  output logic                     sad_valid,
  output logic [ACC_W-1:0]         sad_value,
  output logic [TAG_W-1:0]         sad_tag,
  output logic [ACC_W-1:0]         min_value,
  output logic [TAG_W-1:0]         min_tag,
  output logic                     min_updated,
  output logic                     busy
);

  localparam int SUM_W = PIX_W + $clog2(LANES);
  localparam int EXT_W = ACC_W + 1;

  logic [PIX_W-1:0] diff_d [LANES];
  logic [PIX_W-1:0] diff_q [LANES];
  logic             s1_valid_q, s1_last_q;
  logic [TAG_W-1:0] s1_tag_q;

  logic [SUM_W-1:0] sum_d, s2_sum_q;
  logic             s2_valid_q, s2_last_q;
  logic [TAG_W-1:0] s2_tag_q;

  logic [ACC_W-1:0] acc_q;
  logic             open_q;
  logic [EXT_W-1:0] acc_ext;
  logic [ACC_W-1:0] acc_sat;

  logic             sad_valid_q, min_updated_q;
  logic [ACC_W-1:0] sad_value_q, min_value_q;
  logic [TAG_W-1:0] sad_tag_q, min_tag_q;

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      diff_d[i] = (frame_pix[i*PIX_W +: PIX_W] > window_pix[i*PIX_W +: PIX_W])
                ? frame_pix[i*PIX_W +: PIX_W] - window_pix[i*PIX_W +: PIX_W]
                : window_pix[i*PIX_W +: PIX_W] - frame_pix[i*PIX_W +: PIX_W];
    end
  end

  always_comb begin
    sum_d = '0;
    for (int i = 0; i < LANES; i++) begin
      sum_d = sum_d + SUM_W'(diff_q[i]);
    end
  end

  // One extra bit catches the carry; a saturated acc stays pinned at all ones.
  always_comb begin
    acc_ext = {1'b0, acc_q} + EXT_W'(s2_sum_q);
    acc_sat = acc_ext[ACC_W] ? {ACC_W{1'b1}} : acc_ext[ACC_W-1:0];
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < LANES; i++) diff_q[i] <= '0;
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_tag_q   <= '0;
      s2_sum_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_last_q  <= 1'b0;
      s2_tag_q   <= '0;
    end else begin
      for (int i = 0; i < LANES; i++) diff_q[i] <= diff_d[i];
      s1_valid_q <= in_valid;
      s1_last_q  <= in_valid & in_last;
      if (in_valid && in_last) s1_tag_q <= in_tag;
      s2_sum_q   <= sum_d;
      s2_valid_q <= s1_valid_q;
      s2_last_q  <= s1_last_q;
      s2_tag_q   <= s1_tag_q;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      acc_q         <= '0;
      open_q        <= 1'b0;
      sad_valid_q   <= 1'b0;
      sad_value_q   <= '0;
      sad_tag_q     <= '0;
      min_value_q   <= '1;
      min_tag_q     <= '0;
      min_updated_q <= 1'b0;
    end else begin
      sad_valid_q   <= 1'b0;
      min_updated_q <= 1'b0;
      if (s2_valid_q) begin
        if (s2_last_q) begin
          acc_q       <= '0;
          open_q      <= 1'b0;
          sad_valid_q <= 1'b1;
          sad_value_q <= acc_sat;
          sad_tag_q   <= s2_tag_q;
          // Strict compare keeps the earlier tag on ties; clear forces adoption.
          if (min_clear || (acc_sat < min_value_q)) begin
            min_value_q   <= acc_sat;
            min_tag_q     <= s2_tag_q;
            min_updated_q <= 1'b1;
          end
        end else begin
          acc_q  <= acc_sat;
          open_q <= 1'b1;
        end
      end
      if (min_clear && !(s2_valid_q && s2_last_q)) begin
        min_value_q <= '1;
        min_tag_q   <= '0;
      end
    end
  end

  assign sad_valid   = sad_valid_q;
  assign sad_value   = sad_value_q;
  assign sad_tag     = sad_tag_q;
  assign min_value   = min_value_q;
  assign min_tag     = min_tag_q;
  assign min_updated = min_updated_q;
  assign busy        = s1_valid_q | s2_valid_q | open_q;

endmodule

// File: tb/tb_sad_lane_engine.sv
// Self-checking bench for sad_lane_engine: directed scenarios plus randomized back-to-back blocks
// against a block-level arithmetic model. A second instance with a 12-bit accumulator covers saturation.
module tb_sad_lane_engine;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        in_valid, in_last, min_clear;
  logic [31:0] frame_pix, window_pix, in_tag;

  logic        sad_valid, min_updated, busy;
  logic [31:0] sad_value, sad_tag, min_value, min_tag;
  logic        s_sad_valid, s_min_updated, s_busy;
  logic [11:0] s_sad_value, s_min_value;
  logic [31:0] s_sad_tag, s_min_tag;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] m_min;
  logic [31:0] m_tag;

  always #5 Clk = ~Clk;

  sad_lane_engine #(.LANES(4), .PIX_W(8), .ACC_W(32), .TAG_W(32)) dut (
    .Clk(Clk), .Reset(Reset), .in_valid(in_valid), .in_last(in_last),
    .frame_pix(frame_pix), .window_pix(window_pix), .in_tag(in_tag), .min_clear(min_clear),
    .sad_valid(sad_valid), .sad_value(sad_value), .sad_tag(sad_tag),
    .min_value(min_value), .min_tag(min_tag), .min_updated(min_updated), .busy(busy));

  sad_lane_engine #(.LANES(4), .PIX_W(8), .ACC_W(12), .TAG_W(32)) dut_sat (
    .Clk(Clk), .Reset(Reset), .in_valid(in_valid), .in_last(in_last),
    .frame_pix(frame_pix), .window_pix(window_pix), .in_tag(in_tag), .min_clear(min_clear),
    .sad_valid(s_sad_valid), .sad_value(s_sad_value), .sad_tag(s_sad_tag),
    .min_value(s_min_value), .min_tag(s_min_tag), .min_updated(s_min_updated), .busy(s_busy));

  function automatic int unsigned beat_sad(input logic [31:0] f, input logic [31:0] w);
    int unsigned s = 0;
    for (int i = 0; i < 4; i++) begin
      int unsigned a = 32'(f[i*8 +: 8]);
      int unsigned b = 32'(w[i*8 +: 8]);
      s += (a > b) ? a - b : b - a;
    end
    return s;
  endfunction

  // Best-match rule applied at block granularity.
  task automatic model_complete(input logic [31:0] r, input logic [31:0] tag, input bit clr,
                                output bit upd);
    upd = clr || (r < m_min);
    if (upd) begin
      m_min = r;
      m_tag = tag;
    end
  endtask

  task automatic beat(input logic [31:0] f, input logic [31:0] w, input bit last,
                      input logic [31:0] tag);
    in_valid = 1'b1; in_last = last; frame_pix = f; window_pix = w; in_tag = tag;
    @(posedge Clk); #1;
    in_valid = 1'b0; in_last = 1'b0; in_tag = $urandom;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge Clk); #1; end
  endtask

  task automatic wait_sad(output int cyc);
    cyc = 0;
    do begin
      @(negedge Clk);
      cyc++;
    end while (!sad_valid && cyc < 20);
    if (!sad_valid) cyc = -1;
  endtask

  task automatic test_reset;
    n_checks++; if (sad_valid !== 1'b0) begin n_fail++; $display("FAIL reset_sad_valid got %0b want 0", sad_valid); end
    n_checks++; if (sad_value !== 32'd0) begin n_fail++; $display("FAIL reset_sad_value got %0d want 0", sad_value); end
    n_checks++; if (sad_tag !== 32'd0) begin n_fail++; $display("FAIL reset_sad_tag got %0h want 0", sad_tag); end
    n_checks++; if (min_value !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL reset_min_value got %0h want ffffffff", min_value); end
    n_checks++; if (min_tag !== 32'd0) begin n_fail++; $display("FAIL reset_min_tag got %0h want 0", min_tag); end
    n_checks++; if ({min_updated, busy} !== 2'b00) begin n_fail++; $display("FAIL reset_upd_busy got %b want 00", {min_updated, busy}); end
  endtask

  task automatic test_single_beat;
    int cyc; bit upd; logic [31:0] exp_v;
    exp_v = beat_sad(32'h1020_3040, 32'h0F25_3048);
    beat(32'h1020_3040, 32'h0F25_3048, 1'b1, 32'hA);
    model_complete(exp_v, 32'hA, 1'b0, upd);
    wait_sad(cyc);
    n_checks++; if (cyc !== 3) begin n_fail++; $display("FAIL single_latency got %0d want 3", cyc); end
    n_checks++; if (sad_value !== exp_v) begin n_fail++; $display("FAIL single_value got %0d want %0d", sad_value, exp_v); end
    n_checks++; if (sad_tag !== 32'hA) begin n_fail++; $display("FAIL single_tag got %0h want a", sad_tag); end
    n_checks++; if ({min_value, min_tag, min_updated} !== {m_min, m_tag, upd})
      begin n_fail++; $display("FAIL single_min got %0d/%0h/%0b want %0d/%0h/%0b", min_value, min_tag, min_updated, m_min, m_tag, upd); end
    @(negedge Clk);
    n_checks++; if ({sad_valid, min_updated, sad_value} !== {2'b00, exp_v})
      begin n_fail++; $display("FAIL single_hold got v%0b u%0b %0d want v0 u0 %0d", sad_valid, min_updated, sad_value, exp_v); end
  endtask

  task automatic test_multi_beat_gap;
    int cyc; int bad_busy = 0; bit upd; int pulses = 0;
    logic [31:0] exp_v = 0;
    for (int b = 0; b < 4; b++) begin
      exp_v += beat_sad(32'hFFFF_FFFF, 32'h0);
      beat(32'hFFFF_FFFF, 32'h0, b == 3, (b == 3) ? 32'h33 : $urandom);
      if (b < 3) begin
        @(negedge Clk); if (busy !== 1'b1) bad_busy++;
      end
      if (b == 1) begin
        for (int g = 0; g < 2; g++) begin idle(1); @(negedge Clk); if (busy !== 1'b1) bad_busy++; end
      end
    end
    model_complete(exp_v, 32'h33, 1'b0, upd);
    wait_sad(cyc);
    n_checks++; if (bad_busy !== 0) begin n_fail++; $display("FAIL gap_busy got %0d low samples want 0", bad_busy); end
    n_checks++; if (cyc !== 3) begin n_fail++; $display("FAIL gap_latency got %0d want 3", cyc); end
    n_checks++; if ({sad_value, sad_tag} !== {exp_v, 32'h33}) begin n_fail++; $display("FAIL gap_value got %0d/%0h want %0d/33", sad_value, sad_tag, exp_v); end
    n_checks++; if ({min_value, min_tag, min_updated} !== {m_min, m_tag, upd})
      begin n_fail++; $display("FAIL gap_min got %0d/%0h/%0b want %0d/%0h/%0b", min_value, min_tag, min_updated, m_min, m_tag, upd); end
    repeat (4) begin @(negedge Clk); if (sad_valid) pulses++; end
    n_checks++; if (pulses !== 0) begin n_fail++; $display("FAIL gap_single_pulse got %0d extra pulses want 0", pulses); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL gap_idle_busy got %0b want 0", busy); end
  endtask

  task automatic test_min_ties;
    int cyc; bit upd;
    logic [31:0] vals [3] = '{32'd100, 32'd100, 32'd99};
    logic [31:0] tags [3] = '{32'd5, 32'd7, 32'd9};
    min_clear = 1'b1; idle(1); min_clear = 1'b0;
    m_min = 32'hFFFF_FFFF; m_tag = 0;
    for (int k = 0; k < 3; k++) begin
      beat(vals[k], 32'h0, 1'b1, tags[k]);
      model_complete(vals[k], tags[k], 1'b0, upd);
      wait_sad(cyc);
      n_checks++; if (sad_value !== vals[k]) begin n_fail++; $display("FAIL tie_value[%0d] got %0d want %0d", k, sad_value, vals[k]); end
      n_checks++; if ({min_value, min_tag, min_updated} !== {m_min, m_tag, upd})
        begin n_fail++; $display("FAIL tie_min[%0d] got %0d/%0h/%0b want %0d/%0h/%0b", k, min_value, min_tag, min_updated, m_min, m_tag, upd); end
    end
  endtask

  task automatic test_min_clear;
    int cyc; bit upd;
    beat(32'd10, 32'h0, 1'b1, 32'd1);
    model_complete(32'd10, 32'd1, 1'b0, upd);
    wait_sad(cyc);
    n_checks++; if ({min_value, min_tag, min_updated} !== {m_min, m_tag, upd})
      begin n_fail++; $display("FAIL clr_setup got %0d/%0h/%0b want %0d/%0h/%0b", min_value, min_tag, min_updated, m_min, m_tag, upd); end
    idle(1);
    // 500 = 4 lanes of 125; min_clear lands on the completion edge.
    beat(32'h7D7D_7D7D, 32'h0, 1'b1, 32'h77);
    idle(1);
    min_clear = 1'b1; idle(1); min_clear = 1'b0;
    model_complete(32'd500, 32'h77, 1'b1, upd);
    @(negedge Clk);
    n_checks++; if ({sad_valid, sad_value} !== {1'b1, 32'd500}) begin n_fail++; $display("FAIL clr_done got v%0b %0d want v1 500", sad_valid, sad_value); end
    n_checks++; if ({min_value, min_tag, min_updated} !== {m_min, m_tag, upd})
      begin n_fail++; $display("FAIL clr_with_done got %0d/%0h/%0b want %0d/%0h/%0b", min_value, min_tag, min_updated, m_min, m_tag, upd); end
    idle(1);
    min_clear = 1'b1; idle(1); min_clear = 1'b0;
    m_min = 32'hFFFF_FFFF; m_tag = 0;
    @(negedge Clk);
    n_checks++; if ({min_value, min_tag, min_updated, sad_valid} !== {m_min, m_tag, 2'b00})
      begin n_fail++; $display("FAIL clr_alone got %0h/%0h/u%0b/v%0b want %0h/%0h/u0/v0", min_value, min_tag, min_updated, sad_valid, m_min, m_tag); end
  endtask

  task automatic test_saturation;
    int cyc; bit upd; logic [31:0] raw = 0; logic [11:0] exp_s;
    for (int b = 0; b < 5; b++) begin
      raw += beat_sad(32'hFFFF_FFFF, 32'h0);
      beat(32'hFFFF_FFFF, 32'h0, b == 4, 32'h5A);
    end
    exp_s = (raw > 32'd4095) ? 12'hFFF : raw[11:0];
    model_complete(raw, 32'h5A, 1'b0, upd);
    wait_sad(cyc);
    n_checks++; if (s_sad_valid !== 1'b1 || s_sad_value !== exp_s) begin n_fail++; $display("FAIL sat_value got v%0b %0d want v1 %0d", s_sad_valid, s_sad_value, exp_s); end
    n_checks++; if (sad_value !== raw) begin n_fail++; $display("FAIL sat_wide_value got %0d want %0d", sad_value, raw); end
    n_checks++; if ({min_value, min_tag, min_updated} !== {m_min, m_tag, upd})
      begin n_fail++; $display("FAIL sat_min got %0d/%0h/%0b want %0d/%0h/%0b", min_value, min_tag, min_updated, m_min, m_tag, upd); end
    raw = beat_sad(32'hFFFF_FFFF, 32'h0);
    beat(32'hFFFF_FFFF, 32'h0, 1'b1, 32'h5B);
    model_complete(raw, 32'h5B, 1'b0, upd);
    wait_sad(cyc);
    n_checks++; if (s_sad_value !== raw[11:0]) begin n_fail++; $display("FAIL sat_after got %0d want %0d", s_sad_value, raw); end
  endtask

  task automatic test_reset_in_flight;
    int cyc; int pulses = 0; bit upd;
    for (int b = 0; b < 4; b++) beat($urandom, $urandom, 1'b0, $urandom);
    Reset = 1'b0; #1;
    m_min = 32'hFFFF_FFFF; m_tag = 0;
    n_checks++; if ({sad_valid, sad_value, sad_tag, min_updated, busy} !== {1'b0, 32'd0, 32'd0, 2'b00})
      begin n_fail++; $display("FAIL rst_async got v%0b %0d/%0h u%0b b%0b want all zero", sad_valid, sad_value, sad_tag, min_updated, busy); end
    n_checks++; if ({min_value, min_tag} !== {m_min, m_tag}) begin n_fail++; $display("FAIL rst_async_min got %0h/%0h want %0h/0", min_value, min_tag, m_min); end
    @(negedge Clk); Reset = 1'b1;
    repeat (6) begin @(negedge Clk); if (sad_valid || busy) pulses++; end
    n_checks++; if (pulses !== 0) begin n_fail++; $display("FAIL rst_no_ghost got %0d active samples want 0", pulses); end
    @(posedge Clk); #1;
    beat(32'h1020_3040, 32'h0F25_3048, 1'b1, 32'hB);
    model_complete(beat_sad(32'h1020_3040, 32'h0F25_3048), 32'hB, 1'b0, upd);
    wait_sad(cyc);
    n_checks++; if ({sad_value, min_value, min_tag, min_updated} !== {32'd14, m_min, m_tag, upd})
      begin n_fail++; $display("FAIL rst_recover got %0d/%0d/%0h/%0b want 14/%0d/%0h/%0b", sad_value, min_value, min_tag, min_updated, m_min, m_tag, upd); end
  endtask

  task automatic test_back_to_back;
    localparam int NB = 40;
    logic [31:0] q_val [$];
    logic [31:0] q_tag [$];
    int got = 0; int budget = 0; int bad = 0;
    fork
      begin
        for (int b = 0; b < NB; b++) begin
          int nb = $urandom_range(1, 4);
          logic [31:0] s = 0;
          logic [31:0] t = $urandom;
          for (int k = 0; k < nb; k++) begin
            logic [31:0] f = $urandom;
            logic [31:0] w = $urandom;
            s += beat_sad(f, w);
            if (k == nb - 1) begin q_val.push_back(s); q_tag.push_back(t); end
            beat(f, w, k == nb - 1, t);
            if (k < nb - 1 && $urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
          end
        end
      end
      begin
        while (got < NB && budget < 3000) begin
          @(negedge Clk); budget++;
          if (sad_valid) begin
            bit upd; logic [31:0] ev, et;
            ev = q_val.pop_front(); et = q_tag.pop_front();
            model_complete(ev, et, 1'b0, upd);
            got++;
            n_checks++;
            if ({sad_value, sad_tag, min_value, min_tag, min_updated} !== {ev, et, m_min, m_tag, upd}) begin
              n_fail++; bad++;
              if (bad < 5) $display("FAIL b2b[%0d] got %0d/%0h min %0d/%0h u%0b want %0d/%0h min %0d/%0h u%0b",
                                    got, sad_value, sad_tag, min_value, min_tag, min_updated, ev, et, m_min, m_tag, upd);
            end
          end
        end
      end
    join
    n_checks++; if (got !== NB) begin n_fail++; $display("FAIL b2b_count got %0d blocks want %0d", got, NB); end
  endtask

  initial begin
    Reset = 1'b0; in_valid = 1'b0; in_last = 1'b0; min_clear = 1'b0;
    frame_pix = '0; window_pix = '0; in_tag = '0;
    m_min = 32'hFFFF_FFFF; m_tag = 0;
    repeat (3) @(posedge Clk);
    @(negedge Clk); Reset = 1'b1;
    @(negedge Clk);
    test_reset;
    @(posedge Clk); #1;
    test_single_beat;
    idle(1);
    test_multi_beat_gap;
    idle(1);
    test_min_ties;
    idle(1);
    test_min_clear;
    idle(1);
    test_saturation;
    idle(1);
    test_reset_in_flight;
    idle(1);
    test_back_to_back;
    idle(4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
